// File: rtl/mcu_pkg.sv
// Shared types and constants for the 8-bit microcontroller datapath.
// Purely declarative: no logic, no latency.
// No flow control: definitions only.
package mcu_pkg;

    localparam int DATA_W = 8;
    localparam int FLAG_W = 4;

    // Bit positions of the status flags inside sr: {Z,C,S,O}
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_MOV  = 4'b0010,
        ALU_PASS = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOT1 = 4'b0111,
        ALU_INC  = 4'b1000,
        ALU_DEC  = 4'b1001,
        ALU_SHL  = 4'b1010,
        ALU_SHR  = 4'b1011,
        ALU_ROL  = 4'b1100,
        ALU_ROR  = 4'b1101,
        ALU_RSUB = 4'b1110,
        ALU_NOT2 = 4'b1111
    } alu_mode_e;

endpackage

// File: rtl/mcu_alu.sv
// Combinational 8-bit ALU with {Z,C,S,O} flag generation; shifter present only with MCU_DP_SHIFT_EN.
// Latency: zero cycles, result and flags valid in the same cycle as the operands.
// No backpressure: pure function of its inputs.
module mcu_alu
    import mcu_pkg::*;
(
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic [3:0]        mode_i,
    input  logic              en_i,
    input  logic [FLAG_W-1:0] flags_i,
    output logic [DATA_W-1:0] res_o,
    output logic [FLAG_W-1:0] flags_o
);

    logic [DATA_W-1:0] res;
    logic [DATA_W:0]   wide;
    logic              c_flag;
    logic              o_flag;

    // Operation decode: result, carry/borrow and signed overflow per mode
    always_comb begin
        res    = '0;
        wide   = '0;
        c_flag = flags_i[FLAG_C];
        o_flag = 1'b0;
        case (alu_mode_e'(mode_i))
            ALU_ADD: begin
                wide   = {1'b0, op1_i} + {1'b0, op2_i};
                res    = wide[DATA_W-1:0];
                c_flag = wide[DATA_W];
                o_flag = (op1_i[7] == op2_i[7]) && (res[7] != op1_i[7]);
            end
            ALU_SUB: begin
                // Bit 8 of the 9-bit difference is the borrow
                wide   = {1'b0, op1_i} - {1'b0, op2_i};
                res    = wide[DATA_W-1:0];
                c_flag = wide[DATA_W];
                o_flag = (op1_i[7] != op2_i[7]) && (res[7] != op1_i[7]);
            end
            ALU_RSUB: begin
                wide   = {1'b0, op2_i} - {1'b0, op1_i};
                res    = wide[DATA_W-1:0];
                c_flag = wide[DATA_W];
                o_flag = (op2_i[7] != op1_i[7]) && (res[7] != op2_i[7]);
            end
            ALU_INC: begin
                wide   = {1'b0, op1_i} + 9'd1;
                res    = wide[DATA_W-1:0];
                c_flag = wide[DATA_W];
                o_flag = !op1_i[7] && res[7];
            end
            ALU_DEC: begin
                wide   = {1'b0, op1_i} - 9'd1;
                res    = wide[DATA_W-1:0];
                c_flag = wide[DATA_W];
                o_flag = op1_i[7] && !res[7];
            end
            ALU_MOV:  res = op2_i;
            ALU_PASS: res = op1_i;
            ALU_AND:  res = op1_i & op2_i;
            ALU_OR:   res = op1_i | op2_i;
            ALU_XOR:  res = op1_i ^ op2_i;
            ALU_NOT1: res = ~op1_i;
            ALU_NOT2: res = ~op2_i;
`ifdef MCU_DP_SHIFT_EN
            ALU_SHL: begin
                res    = {op1_i[6:0], 1'b0};
                c_flag = op1_i[7];
            end
            ALU_SHR: begin
                res    = {1'b0, op1_i[7:1]};
                c_flag = op1_i[0];
            end
            ALU_ROL: begin
                res    = {op1_i[6:0], op1_i[7]};
                c_flag = op1_i[7];
            end
            ALU_ROR: begin
                res    = {op1_i[0], op1_i[7:1]};
                c_flag = op1_i[0];
            end
`else
            // Without the shifter the shift codes degrade to PASS and leave C and O alone
            ALU_SHL, ALU_SHR, ALU_ROL, ALU_ROR: begin
                res    = op1_i;
                o_flag = flags_i[FLAG_O];
            end
`endif
            default: res = op1_i;
        endcase
    end

    // Disabled ALU drives zero and reflects the incoming flags unchanged
    always_comb begin
        res_o   = '0;
        flags_o = flags_i;
        if (en_i) begin
            res_o           = res;
            flags_o[FLAG_Z] = (res == '0);
            flags_o[FLAG_C] = c_flag;
            flags_o[FLAG_S] = res[7];
            flags_o[FLAG_O] = o_flag;
        end
    end

endmodule

// File: rtl/mcu_datapath.sv
// Execution datapath: ALU, operand-2 mux, PC incrementer/next-PC mux, and pc/acc/sr registers.
// Latency: alu_out combinational; pc/acc/sr visible one cycle after their enable (MCU_DP_SHIFT_EN adds the shifter).
// No backpressure: the control unit sequences every enable; registers load unconditionally when enabled.
module mcu_datapath
    import mcu_pkg::*;
(
    input  logic        clk,
    input  logic        rs_n,
    input  logic        clr,
    input  logic        pc_e,
    input  logic        acc_e,
    input  logic        sr_e,
    input  logic        alu_e,
    input  logic [3:0]  alu_mode,
    input  logic        mux1_sel,
    input  logic        mux2_sel,
    input  logic [7:0]  imm,
    input  logic [7:0]  dr,
    output logic [7:0]  pc,
    output logic [7:0]  acc,
    output logic [3:0]  sr,
    output logic [7:0]  alu_out
);

    logic [DATA_W-1:0] pc_q,  pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [FLAG_W-1:0] sr_q,  sr_d;

    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] alu_res;
    logic [FLAG_W-1:0] alu_flags;

    // 8-bit incrementer wraps naturally from 0xFF to 0x00
    assign pc_inc  = pc_q + 8'd1;
    assign pc_next = mux1_sel ? imm : pc_inc;
    assign op2     = mux2_sel ? imm : dr;

    mcu_alu u_alu (
        .op1_i   (acc_q),
        .op2_i   (op2),
        .mode_i  (alu_mode),
        .en_i    (alu_e),
        .flags_i (sr_q),
        .res_o   (alu_res),
        .flags_o (alu_flags)
    );

    // Next-state per register: its own enable wins over clr, otherwise hold
    always_comb begin
        pc_d  = pc_q;
        acc_d = acc_q;
        sr_d  = sr_q;

        if (pc_e)      pc_d = pc_next;
        else if (clr)  pc_d = '0;

        if (acc_e)     acc_d = alu_res;
        else if (clr)  acc_d = '0;

        if (sr_e)      sr_d = alu_flags;
        else if (clr)  sr_d = '0;
    end

    // State registers with asynchronous clear on rs_n
    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            pc_q  <= '0;
            acc_q <= '0;
            sr_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            acc_q <= acc_d;
            sr_q  <= sr_d;
        end
    end

    assign pc      = pc_q;
    assign acc     = acc_q;
    assign sr      = sr_q;
    assign alu_out = alu_res;

endmodule

// File: tb/tb_mcu_datapath.sv
// Self-checking bench for mcu_datapath: vector table for ALU modes plus hand sequences for reset/PC/priority.
// Expected register values are queued when stimulus is driven and popped after the clock edge.
// Follows MCU_DP_SHIFT_EN for shift-mode expectations.
module tb_mcu_datapath;
    import mcu_pkg::*;

    logic       clk = 1'b0;
    logic       rs_n;
    logic       clr, pc_e, acc_e, sr_e, alu_e, mux1_sel, mux2_sel;
    logic [3:0] alu_mode;
    logic [7:0] imm, dr;
    logic [7:0] pc, acc, alu_out;
    logic [3:0] sr;

    mcu_datapath dut (
        .clk      (clk),
        .rs_n     (rs_n),
        .clr      (clr),
        .pc_e     (pc_e),
        .acc_e    (acc_e),
        .sr_e     (sr_e),
        .alu_e    (alu_e),
        .alu_mode (alu_mode),
        .mux1_sel (mux1_sel),
        .mux2_sel (mux2_sel),
        .imm      (imm),
        .dr       (dr),
        .pc       (pc),
        .acc      (acc),
        .sr       (sr),
        .alu_out  (alu_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mode;
        logic       m2;
        logic [7:0] imm;
        logic [7:0] dr;
        logic [7:0] acc0;
        logic       pre_c;
        logic       en;
        logic [7:0] exp_res;
        logic [3:0] exp_sr;
    } vec_t;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] acc;
        logic [3:0] sr;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        clr = 0; pc_e = 0; acc_e = 0; sr_e = 0; alu_e = 0;
        mux1_sel = 0; mux2_sel = 0; alu_mode = 4'h0; imm = 8'h00; dr = 8'h00;
    endtask

    // Queue the expected registers, take one edge, then compare against the popped entry
    task automatic clock_in(input logic [7:0] e_pc, input logic [7:0] e_acc,
                            input logic [3:0] e_sr, input string nm);
        exp_t e;
        exp_t g;
        e.pc = e_pc; e.acc = e_acc; e.sr = e_sr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({nm, ".pc"},  pc,  g.pc);
        chk({nm, ".acc"}, acc, g.acc);
        chk({nm, ".sr"},  {4'h0, sr}, {4'h0, g.sr});
    endtask

    task automatic add(input logic [3:0] mode, input logic m2, input logic [7:0] i8,
                       input logic [7:0] d8, input logic [7:0] a0, input logic pre,
                       input logic en, input logic [7:0] res, input logic [3:0] s);
        vec_t v;
        v.mode = mode; v.m2 = m2; v.imm = i8; v.dr = d8; v.acc0 = a0;
        v.pre_c = pre; v.en = en; v.exp_res = res; v.exp_sr = s;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sr_pre;

        // sr is {Z,C,S,O}; pre_c=1 means incoming sr = 4'b0110, else 4'b0000
        //   mode      m2   imm    dr     acc0  pre en  result  sr
        add(ALU_ADD,  1, 8'h01, 8'h00, 8'h7F, 0, 1, 8'h80, 4'b0011);
        add(ALU_SUB,  0, 8'h00, 8'h05, 8'h05, 0, 1, 8'h00, 4'b1000);
        add(ALU_SUB,  0, 8'h00, 8'h06, 8'h05, 0, 1, 8'hFF, 4'b0110);
        add(ALU_ADD,  1, 8'h01, 8'h00, 8'hFF, 0, 1, 8'h00, 4'b1100);
        add(ALU_MOV,  1, 8'h00, 8'h00, 8'h12, 1, 1, 8'h00, 4'b1100);
        add(ALU_AND,  0, 8'h00, 8'h3C, 8'hF0, 0, 1, 8'h30, 4'b0000);
        add(ALU_OR,   0, 8'h00, 8'h01, 8'h80, 1, 1, 8'h81, 4'b0110);
        add(ALU_XOR,  0, 8'h00, 8'hAA, 8'hAA, 0, 1, 8'h00, 4'b1000);
        add(ALU_NOT1, 0, 8'h00, 8'h00, 8'h0F, 0, 1, 8'hF0, 4'b0010);
        add(ALU_INC,  0, 8'h00, 8'h00, 8'h7F, 0, 1, 8'h80, 4'b0011);
        add(ALU_INC,  0, 8'h00, 8'h00, 8'hFF, 0, 1, 8'h00, 4'b1100);
        add(ALU_DEC,  0, 8'h00, 8'h00, 8'h00, 0, 1, 8'hFF, 4'b0110);
        add(ALU_DEC,  0, 8'h00, 8'h00, 8'h80, 0, 1, 8'h7F, 4'b0001);
        add(ALU_RSUB, 1, 8'h01, 8'h00, 8'h03, 0, 1, 8'hFE, 4'b0110);
        add(ALU_RSUB, 1, 8'h80, 8'h00, 8'h01, 0, 1, 8'h7F, 4'b0001);
        add(ALU_SUB,  1, 8'h01, 8'h00, 8'h80, 0, 1, 8'h7F, 4'b0001);
        add(ALU_NOT2, 1, 8'hFF, 8'h00, 8'h12, 1, 1, 8'h00, 4'b1100);
        add(ALU_PASS, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h00, 4'b1100);
        add(ALU_ADD,  1, 8'h11, 8'h00, 8'h55, 1, 0, 8'h00, 4'b0110);
`ifdef MCU_DP_SHIFT_EN
        add(ALU_SHL,  0, 8'h00, 8'h00, 8'h81, 0, 1, 8'h02, 4'b0100);
        add(ALU_SHR,  0, 8'h00, 8'h00, 8'h01, 1, 1, 8'h00, 4'b1100);
        add(ALU_ROL,  0, 8'h00, 8'h00, 8'h81, 1, 1, 8'h03, 4'b0100);
        add(ALU_ROR,  0, 8'h00, 8'h00, 8'h02, 1, 1, 8'h01, 4'b0000);
`else
        add(ALU_SHL,  0, 8'h00, 8'h00, 8'h81, 0, 1, 8'h81, 4'b0010);
        add(ALU_SHR,  0, 8'h00, 8'h00, 8'h01, 1, 1, 8'h01, 4'b0100);
        add(ALU_ROL,  0, 8'h00, 8'h00, 8'h81, 1, 1, 8'h81, 4'b0110);
        add(ALU_ROR,  0, 8'h00, 8'h00, 8'h02, 1, 1, 8'h02, 4'b0100);
`endif

        // Power-on reset
        idle();
        rs_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("por.pc", pc, 8'h00);
        chk("por.acc", acc, 8'h00);
        chk("por.sr", {4'h0, sr}, 8'h00);
        rs_n = 1'b1;

        // Table-driven ALU vectors
        foreach (tbl[k]) begin
            sr_pre = tbl[k].pre_c ? 4'b0110 : 4'b0000;
            idle(); clr = 1;
            clock_in(8'h00, 8'h00, 4'h0, $sformatf("v%0d.clr", k));
            if (tbl[k].pre_c) begin
                idle(); alu_e = 1; sr_e = 1; alu_mode = ALU_DEC;
                clock_in(8'h00, 8'h00, 4'b0110, $sformatf("v%0d.prec", k));
            end
            idle(); alu_e = 1; acc_e = 1; mux2_sel = 1; imm = tbl[k].acc0; alu_mode = ALU_MOV;
            clock_in(8'h00, tbl[k].acc0, sr_pre, $sformatf("v%0d.ld", k));
            idle();
            alu_e = tbl[k].en; acc_e = 1; sr_e = 1; alu_mode = tbl[k].mode;
            mux2_sel = tbl[k].m2; imm = tbl[k].imm; dr = tbl[k].dr;
            #1;
            chk($sformatf("v%0d.alu_out", k), alu_out, tbl[k].exp_res);
            clock_in(8'h00, tbl[k].exp_res, tbl[k].exp_sr, $sformatf("v%0d.op", k));
        end

        // Asynchronous reset asserted mid-cycle with live state
        idle(); clr = 1;
        clock_in(8'h00, 8'h00, 4'h0, "mr.clr");
        idle(); pc_e = 1; mux1_sel = 1; imm = 8'h12;
        clock_in(8'h12, 8'h00, 4'h0, "mr.pc");
        idle(); alu_e = 1; acc_e = 1; mux2_sel = 1; imm = 8'h34; alu_mode = ALU_MOV;
        clock_in(8'h12, 8'h34, 4'h0, "mr.acc");
        idle(); alu_e = 1; sr_e = 1; alu_mode = ALU_NOT1;
        clock_in(8'h12, 8'h34, 4'b0010, "mr.sr");
        idle(); pc_e = 1; acc_e = 1; sr_e = 1; alu_e = 1; alu_mode = ALU_NOT1;
        #3;
        rs_n = 1'b0;
        #1;
        chk("mr.async.pc", pc, 8'h00);
        chk("mr.async.acc", acc, 8'h00);
        chk("mr.async.sr", {4'h0, sr}, 8'h00);
        @(posedge clk);
        #1;
        idle();
        rs_n = 1'b1;
        clock_in(8'h00, 8'h00, 4'h0, "mr.rel");

        // PC incrementer wrap and jump; sr must be untouched by PC moves
        idle(); alu_e = 1; sr_e = 1; alu_mode = ALU_NOT1;
        clock_in(8'h00, 8'h00, 4'b0010, "pc.sr");
        idle(); pc_e = 1; mux1_sel = 1; imm = 8'hFF;
        clock_in(8'hFF, 8'h00, 4'b0010, "pc.jff");
        idle(); pc_e = 1;
        clock_in(8'h00, 8'h00, 4'b0010, "pc.wrap");
        idle(); pc_e = 1; mux1_sel = 1; imm = 8'h07;
        clock_in(8'h07, 8'h00, 4'b0010, "pc.j07");
        idle(); pc_e = 1;
        clock_in(8'h08, 8'h00, 4'b0010, "pc.inc");
        idle();
        clock_in(8'h08, 8'h00, 4'b0010, "pc.hold");

        // Enable beats clr per register
        idle(); alu_e = 1; acc_e = 1; mux2_sel = 1; imm = 8'h5A; alu_mode = ALU_MOV;
        clock_in(8'h08, 8'h5A, 4'b0010, "pr.ld");
        idle(); pc_e = 1; clr = 1;
        clock_in(8'h09, 8'h00, 4'h0, "pr.pc_clr");
        idle(); alu_e = 1; acc_e = 1; clr = 1; mux2_sel = 1; imm = 8'h3C; alu_mode = ALU_MOV;
        clock_in(8'h00, 8'h3C, 4'h0, "pr.acc_clr");
        idle(); alu_e = 1; sr_e = 1; clr = 1; alu_mode = ALU_NOT1;
        clock_in(8'h00, 8'h00, 4'b0010, "pr.sr_clr");
        idle(); alu_e = 1; acc_e = 1; mux2_sel = 1; imm = 8'h77; alu_mode = ALU_MOV;
        clock_in(8'h00, 8'h77, 4'b0010, "pr.ld2");
        idle(); alu_e = 0; acc_e = 1; sr_e = 1; mux2_sel = 1; imm = 8'h11; alu_mode = ALU_ADD;
        #1;
        chk("pr.dis.alu_out", alu_out, 8'h00);
        clock_in(8'h00, 8'h00, 4'b0010, "pr.dis");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
